// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage.
// Holds the FSM encoding, NOP word, PC step and IF/ID bundle.
package fetch_stage_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fstate_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{
    pc4:   32'h0,
    instr: NOP_WORD,
    valid: 1'b0
  };

  function automatic logic [31:0] align_word(
    input logic [31:0] a
  );
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// IF/ID register control bundle.
// Master drives load/hold/bubble controls, slave returns state.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic  hold;
  logic  bubble;
  ifid_t d;
  ifid_t q;

  modport master (
    output hold,
    output bubble,
    output d,
    input  q
  );

  modport slave (
    input  hold,
    input  bubble,
    input  d,
    output q
  );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
// Priority: reset, bubble, hold, load.
module ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_stage_if.slave  bus
);

  ifid_t ifid_q;

  // Register the fetched bundle, inserting a bubble when asked.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ifid_q <= IFID_BUBBLE;
    end else begin
      unique case (1'b1)
        bus.bubble: ifid_q <= IFID_BUBBLE;
        bus.hold:   ifid_q <= ifid_q;
        default:    ifid_q <= bus.d;
      endcase
    end
  end

  assign bus.q = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, RUN/HALT FSM, fetch counter.
// Memory read is combinational; IF/ID lives in ifid_reg.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_addr_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic        halted_o,
  output logic [15:0] fetch_cnt_o
);

  localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);

  fstate_e     state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] tgt_al;
  logic [31:0] pc_nx;

  fetch_stage_if ifid_bus ();

  assign tgt_al = align_word(target_i);
  assign pc_nx  = pc_q + PC_INC;

  // PC, FSM and counter state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      pc_q    <= 32'h0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: redirect beats stall beats normal advance.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    cnt_d           = cnt_q;
    ifid_bus.hold   = 1'b0;
    ifid_bus.bubble = 1'b0;
    ifid_bus.d      = '{
      pc4:   pc_nx,
      instr: instr_i,
      valid: 1'b1
    };
    if (redirect_i) begin
      pc_d            = tgt_al;
      ifid_bus.bubble = 1'b1;
      state_d         = (tgt_al < LIMIT) ? ST_RUN
                                         : ST_HALT;
    end else if (stall_i) begin
      ifid_bus.hold = 1'b1;
    end else if (state_q == ST_RUN && pc_q < LIMIT) begin
      pc_d  = pc_nx;
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q
                                  : cnt_q + 16'd1;
    end else begin
      ifid_bus.bubble = 1'b1;
      state_d         = ST_HALT;
    end
  end

  ifid_reg u_ifid (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (ifid_bus.slave)
  );

  assign pc_addr_o    = pc_q;
  assign ifid_pc4_o   = ifid_bus.q.pc4;
  assign ifid_instr_o = ifid_bus.q.instr;
  assign ifid_valid_o = ifid_bus.q.valid;
  assign halted_o     = (state_q == ST_HALT);
  assign fetch_cnt_o  = cnt_q;

endmodule
